lcd_panel_model: RTL and testbench

LCD_PANEL_MODEL -- requirements
Module: lcd_panel_model

---
 rtl/lcd_panel_model_pkg.sv | 36 +++
 rtl/lcd_panel_model_strobe.sv | 39 +++
 rtl/lcd_panel_model.sv | 118 +++++++++++
 tb/tb_lcd_panel_model.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_panel_model_pkg.sv
// Shared constants for the character-LCD panel model: opcode masks, DDRAM geometry and helpers.
package lcd_panel_model_pkg;

  localparam logic [7:0] LCD_BLANK   = 8'h20;
  localparam int         DDRAM_DEPTH = 32;
  localparam logic [4:0] LAST_CELL   = 5'(DDRAM_DEPTH - 1);
  localparam logic [6:0] ROW1_BASE   = 7'h40;
  localparam logic [6:0] ROW_LEN     = 7'h10;

  // Instruction opcodes are recognised by their leading one: value under mask
  localparam logic [7:0] OP_CLEAR      = 8'h01;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE;
  localparam logic [7:0] OP_HOME_VAL   = 8'h02;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] OP_ENTRY_VAL  = 8'h04;
  localparam logic [7:0] OP_DISP_MASK  = 8'hF8;
  localparam logic [7:0] OP_DISP_VAL   = 8'h08;
  localparam logic [7:0] OP_SHIFT_MASK = 8'hF0;
  localparam logic [7:0] OP_SHIFT_VAL  = 8'h10;
  localparam logic [7:0] OP_DDRAM_MASK = 8'h80;
  localparam logic [7:0] OP_DDRAM_VAL  = 8'h80;

  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_CLEAR = 1'b1;

  function automatic logic op_match(input logic [7:0] data, input logic [7:0] mask,
                                    input logic [7:0] value);
    return (data & mask) == value;
  endfunction

  // Five-bit arithmetic gives the 31->0 and 0->31 wrap for free
  function automatic logic [4:0] ac_step(input logic [4:0] ac, input logic inc);
    return inc ? ac + 5'd1 : ac - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_panel_model_strobe.sv
// Enable-strobe falling-edge detector; holds the bus fields seen while the strobe was high.
module lcd_strobe_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  output logic       txn_valid,
  output logic       txn_rs,
  output logic       txn_rw,
  output logic [7:0] txn_data
);

  logic       e_q;
  logic       rs_q;
  logic       rw_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q    <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      e_q    <= lcd_e;
      rs_q   <= lcd_rs;
      rw_q   <= lcd_rw;
      data_q <= lcd_data;
    end
  end

  assign txn_valid = e_q & ~lcd_e;
  assign txn_rs    = rs_q;
  assign txn_rw    = rw_q;
  assign txn_data  = data_q;

endmodule

// File: rtl/lcd_panel_model.sv
// Behavioural 2x16 character-LCD controller: instruction decode, address counter and DDRAM.
module lcd_panel_model
  import lcd_panel_model_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_index,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       busy,
  output logic [2:0] err
);

  logic       txn_valid;
  logic       txn_rs;
  logic       txn_rw;
  logic [7:0] txn_data;

  logic [0:0] state;
  logic [4:0] clr_cnt;
  logic [4:0] ac;
  logic       inc_dir;
  logic [7:0] ddram [DDRAM_DEPTH];

  logic       accept;
  logic       drop;
  logic       data_wr;
  logic [6:0] addr7;
  logic       addr_row0;
  logic       addr_row1;
  logic [4:0] addr_ac;

  lcd_strobe_capture u_strobe (
    .clk      (clk),
    .rst      (rst),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .txn_valid(txn_valid),
    .txn_rs   (txn_rs),
    .txn_rw   (txn_rw),
    .txn_data (txn_data)
  );

  assign busy    = (state == STATE_CLEAR);
  assign accept  = txn_valid & ~busy;
  assign drop    = txn_valid & busy;
  assign data_wr = accept & txn_rs & ~txn_rw;

  // Row 0 lives at 0x00-0x0F, row 1 at 0x40-0x4F; everything else is off-panel
  assign addr7     = txn_data[6:0];
  assign addr_row0 = (addr7 < ROW_LEN);
  assign addr_row1 = (addr7 >= ROW1_BASE) && (addr7 < ROW1_BASE + ROW_LEN);
  assign addr_ac   = addr_row0 ? addr7[4:0] : {1'b1, addr7[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STATE_IDLE;
      clr_cnt    <= 5'd0;
      ac         <= 5'd0;
      inc_dir    <= 1'b1;
      display_on <= 1'b0;
      err        <= 3'b000;
    end else begin
      if (state == STATE_CLEAR) begin
        clr_cnt <= clr_cnt + 5'd1;
        if (clr_cnt == LAST_CELL) begin
          state   <= STATE_IDLE;
          ac      <= 5'd0;
          inc_dir <= 1'b1;
        end
      end
      if (drop) err[2] <= 1'b1;
      if (accept) begin
        if (txn_rw) begin
          err[0] <= 1'b1;
        end else if (txn_rs) begin
          ac <= ac_step(ac, inc_dir);
        end else if (txn_data == OP_CLEAR) begin
          state   <= STATE_CLEAR;
          clr_cnt <= 5'd0;
        end else if (op_match(txn_data, OP_DDRAM_MASK, OP_DDRAM_VAL)) begin
          if (addr_row0 || addr_row1) ac <= addr_ac;
          else err[1] <= 1'b1;
        end else if (op_match(txn_data, OP_SHIFT_MASK, OP_SHIFT_VAL)) begin
          if (!txn_data[3]) ac <= ac_step(ac, txn_data[2]);
        end else if (op_match(txn_data, OP_DISP_MASK, OP_DISP_VAL)) begin
          display_on <= txn_data[2];
        end else if (op_match(txn_data, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
          inc_dir <= txn_data[1];
        end else if (op_match(txn_data, OP_HOME_MASK, OP_HOME_VAL)) begin
          ac <= 5'd0;
        end
      end
    end
  end

  // Read port samples before this edge's write, so a same-cycle write returns the old value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DDRAM_DEPTH; i++) ddram[i] <= LCD_BLANK;
      rd_char <= LCD_BLANK;
    end else begin
      rd_char <= ddram[rd_index];
      if (state == STATE_CLEAR) ddram[clr_cnt] <= LCD_BLANK;
      else if (data_wr) ddram[ac] <= txn_data;
    end
  end

  assign cursor = ac;

endmodule

// File: tb/tb_lcd_panel_model.sv
// Self-checking bench for lcd_panel_model: directed vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_lcd_panel_model;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_index = 5'd0;
  logic [7:0] rd_char;
  logic [4:0] cursor;
  logic       display_on;
  logic       busy;
  logic [2:0] err;

  lcd_panel_model dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data),
    .rd_index  (rd_index),
    .rd_char   (rd_char),
    .cursor    (cursor),
    .display_on(display_on),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] m_mem [32];
  int         m_ac;
  bit         m_id;
  bit         m_disp;
  logic [2:0] m_err;
  int         m_busy;

  typedef struct {
    bit         rs;
    bit         rw;
    logic [7:0] data;
    logic [4:0] cur;
    bit         disp;
    logic [2:0] errv;
    logic [4:0] rd_idx;
    logic [7:0] rd_exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1'b1; m_disp = 1'b0; m_err = 3'b000; m_busy = 0;
  endtask

  task automatic model_accept(input bit was_busy, input bit rs, input bit rw, input logic [7:0] d);
    int addr;
    if (was_busy) m_err[2] = 1'b1;
    else if (rw) m_err[0] = 1'b1;
    else if (rs) begin
      m_mem[m_ac] = d;
      m_ac = m_id ? (m_ac + 1) % 32 : (m_ac + 31) % 32;
    end else if (d == 8'h01) m_busy = 32;
    else if (d >= 2 && d <= 3) m_ac = 0;
    else if (d >= 4 && d <= 7) m_id = d[1];
    else if (d >= 8 && d <= 15) m_disp = d[2];
    else if (d >= 16 && d <= 31) begin
      if (!d[3]) m_ac = d[2] ? (m_ac + 1) % 32 : (m_ac + 31) % 32;
    end else if (d >= 128) begin
      addr = int'(d) - 128;
      if (addr < 16) m_ac = addr;
      else if (addr >= 64 && addr < 80) m_ac = addr - 48;
      else m_err[1] = 1'b1;
    end
  endtask

  // One clock: advance the model across the rising edge, then compare busy
  task automatic tick(input bit acc, input bit rs, input bit rw, input logic [7:0] d);
    bit was_busy;
    @(negedge clk);
    was_busy = (m_busy > 0);
    if (was_busy) begin
      m_busy--;
      if (m_busy == 0) begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_ac = 0; m_id = 1'b1;
      end
    end
    if (acc) model_accept(was_busy, rs, rw, d);
    check_output("busy", 32'(busy), 32'(m_busy > 0));
  endtask

  // Strobe held high for 'hold' cycles; only the last high cycle's bus value counts
  task automatic apply_stimulus(input bit rs, input bit rw, input logic [7:0] d, input int hold);
    for (int h = 1; h < hold; h++) begin
      lcd_e = 1'b1; lcd_rs = 1'($urandom); lcd_rw = 1'($urandom); lcd_data = 8'($urandom);
      tick(1'b0, 1'b0, 1'b0, 8'h00);
    end
    lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    lcd_e = 1'b0; lcd_rs = 1'($urandom); lcd_rw = 1'($urandom); lcd_data = 8'($urandom);
    tick(1'b1, rs, rw, d);
  endtask

  task automatic read_cell(input string name, input int idx, input logic [7:0] exp);
    rd_index = 5'(idx);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_output(name, 32'(rd_char), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] d;
    bit rs, rw;
    int sel;

    vecs[0]  = '{1'b1, 1'b0, 8'h41, 5'd1,  1'b0, 3'b000, 5'd0,  8'h41};
    vecs[1]  = '{1'b0, 1'b0, 8'hC5, 5'd21, 1'b0, 3'b000, 5'd5,  8'h20};
    vecs[2]  = '{1'b1, 1'b0, 8'h42, 5'd22, 1'b0, 3'b000, 5'd21, 8'h42};
    vecs[3]  = '{1'b0, 1'b0, 8'hCF, 5'd31, 1'b0, 3'b000, 5'd5,  8'h20};
    vecs[4]  = '{1'b1, 1'b0, 8'h55, 5'd0,  1'b0, 3'b000, 5'd31, 8'h55};
    vecs[5]  = '{1'b0, 1'b0, 8'h04, 5'd0,  1'b0, 3'b000, 5'd5,  8'h20};
    vecs[6]  = '{1'b1, 1'b0, 8'h56, 5'd31, 1'b0, 3'b000, 5'd0,  8'h56};
    vecs[7]  = '{1'b0, 1'b0, 8'h90, 5'd31, 1'b0, 3'b010, 5'd5,  8'h20};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 5'd31, 1'b0, 3'b011, 5'd5,  8'h20};
    vecs[9]  = '{1'b0, 1'b0, 8'h0C, 5'd31, 1'b1, 3'b011, 5'd5,  8'h20};
    vecs[10] = '{1'b0, 1'b0, 8'h14, 5'd0,  1'b1, 3'b011, 5'd5,  8'h20};
    vecs[11] = '{1'b0, 1'b0, 8'h10, 5'd31, 1'b1, 3'b011, 5'd5,  8'h20};
    vecs[12] = '{1'b0, 1'b0, 8'h18, 5'd31, 1'b1, 3'b011, 5'd5,  8'h20};
    vecs[13] = '{1'b0, 1'b0, 8'h02, 5'd0,  1'b1, 3'b011, 5'd5,  8'h20};
    vecs[14] = '{1'b0, 1'b0, 8'h3F, 5'd0,  1'b1, 3'b011, 5'd5,  8'h20};
    vecs[15] = '{1'b0, 1'b0, 8'h06, 5'd0,  1'b1, 3'b011, 5'd5,  8'h20};
    vecs[16] = '{1'b0, 1'b0, 8'h08, 5'd0,  1'b0, 3'b011, 5'd5,  8'h20};

    model_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_output("rst_cursor", 32'(cursor), 32'd0);
    check_output("rst_disp", 32'(display_on), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_rd_char", 32'(rd_char), 32'h20);
    rst = 1'b1;

    for (int v = 0; v < 17; v++) begin
      apply_stimulus(vecs[v].rs, vecs[v].rw, vecs[v].data, 1);
      check_output($sformatf("vec%0d_cursor", v), 32'(cursor), 32'(vecs[v].cur));
      check_output($sformatf("vec%0d_disp", v), 32'(display_on), 32'(vecs[v].disp));
      check_output($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].errv));
      read_cell($sformatf("vec%0d_rd", v), int'(vecs[v].rd_idx), vecs[v].rd_exp);
    end

    // Clear: write during busy is dropped, busy lasts 32 cycles, panel blank afterwards
    apply_stimulus(1'b0, 1'b0, 8'h01, 1);
    check_output("clear_busy_start", 32'(busy), 32'd1);
    apply_stimulus(1'b1, 1'b0, 8'h77, 1);
    check_output("busy_drop_err2", 32'(err[2]), 32'd1);
    n = 0;
    while (busy && n < 64) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    check_output("clear_len", 32'(n + 2), 32'd32);
    check_output("clear_cursor", 32'(cursor), 32'd0);
    for (int i = 0; i < 32; i++) read_cell($sformatf("clear_cell%0d", i), i, 8'h20);

    rd_index = 5'd0;
    apply_stimulus(1'b1, 1'b0, 8'h99, 1);
    check_output("rd_same_cycle_old", 32'(rd_char), 32'h20);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check_output("rd_after_write", 32'(rd_char), 32'h99);
    check_output("write_cursor", 32'(cursor), 32'd1);

    // Reset in the middle of a clear aborts it
    apply_stimulus(1'b0, 1'b0, 8'h01, 1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_cursor", 32'(cursor), 32'd0);
    check_output("midrst_err", 32'(err), 32'd0);
    check_output("midrst_disp", 32'(display_on), 32'd0);
    check_output("midrst_rd_char", 32'(rd_char), 32'h20);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    read_cell("midrst_cell0", 0, 8'h20);
    read_cell("midrst_cell1", 1, 8'h20);

    for (int t = 0; t < 300; t++) begin
      rs = 1'b0; rw = 1'b0;
      sel = int'($urandom_range(0, 19));
      if (sel < 9) begin rs = 1'b1; d = 8'($urandom); end
      else if (sel < 11) begin rw = 1'b1; rs = 1'($urandom); d = 8'($urandom); end
      else if (sel == 11) d = 8'h01;
      else if (sel < 14) d = 8'(8'h80 | $urandom_range(0, 15));
      else if (sel < 16) d = 8'(8'hC0 | $urandom_range(0, 15));
      else if (sel == 16) d = 8'(8'h80 | $urandom_range(0, 127));
      else if (sel < 19) d = 8'($urandom_range(0, 31));
      else d = 8'($urandom);
      apply_stimulus(rs, rw, d, int'($urandom_range(1, 2)));
      check_output("rnd_cursor", 32'(cursor), 32'(m_ac));
      check_output("rnd_disp", 32'(display_on), 32'(m_disp));
      check_output("rnd_err", 32'(err), 32'(m_err));
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'b0, 8'h00);
      if (m_busy == 0) begin
        sel = int'($urandom_range(0, 31));
        read_cell("rnd_rd_char", sel, m_mem[sel]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
